// File: rtl/map_access_arbiter.sv
// map_access_arbiter: shares the single-port map RAM between the pacman
// collision path (read-modify-write clears), the ghost movement path
// (read-only cell lookups) and the VGA row renderer (full-row reads).
// Also tracks the remaining-dot count used for level completion.
module map_access_arbiter #(
    parameter int COLS      = 40,
    parameter int ROWS      = 32,
    parameter int DOT_TOTAL = 300
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    // pacman lookup / clear
    input  logic                pac_req,
    input  logic [5:0]          pac_x,
    input  logic [4:0]          pac_y,
    output logic                pac_done,
    output logic [3:0]          pac_cell,
    // ghost lookup
    input  logic                gh_req,
    input  logic [5:0]          gh_x,
    input  logic [4:0]          gh_y,
    output logic                gh_done,
    output logic [3:0]          gh_cell,
    // renderer row read
    input  logic                vga_req,
    input  logic [4:0]          vga_row,
    output logic                vga_done,
    output logic [COLS*4-1:0]   vga_word,
    // map RAM port
    output logic [4:0]          ram_addr,
    output logic [COLS*4-1:0]   ram_wdata,
    output logic                ram_wren,
    input  logic [COLS*4-1:0]   ram_q,
    // consumption / level status
    output logic                dot_eaten,
    output logic                pill_eaten,
    output logic [9:0]          dots_left,
    output logic                level_clear
);

    localparam int W  = COLS * 4;
    localparam int AW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_WR
    } state_t;

    typedef enum logic [1:0] {
        ID_PAC,
        ID_GH,
        ID_VGA
    } req_id_t;

    state_t          r_state;
    req_id_t         r_id;
    logic [5:0]      r_col;
    logic            r_oob;
    logic            r_pac_done;
    logic            r_gh_done;
    logic            r_vga_done;
    logic [3:0]      r_pac_cell;
    logic [3:0]      r_gh_cell;
    logic [W-1:0]    r_vga_word;
    logic [4:0]      r_ram_addr;
    logic [W-1:0]    r_ram_wdata;
    logic            r_ram_wren;
    logic            r_dot_eaten;
    logic            r_pill_eaten;
    logic [9:0]      r_dots_left;
    logic            r_rr_gh;        // round-robin pointer: 0 = pacman next, 1 = ghost next
    logic [1:0]      r_vga_streak;   // consecutive VGA grants, saturating at 2

    logic            w_gnt_vga;
    logic            w_gnt_pac;
    logic            w_gnt_gh;
    logic            w_vga_block;
    logic            w_pac_oob;
    logic            w_gh_oob;
    logic [AW-1:0]   w_msb;
    logic [3:0]      w_raw_cell;
    logic [3:0]      w_cell;
    logic [W-1:0]    w_clear_word;
    logic            w_clear_hit;

    assign w_pac_oob = (32'(pac_x) >= 32'(COLS)) || (32'(pac_y) >= 32'(ROWS));
    assign w_gh_oob  = (32'(gh_x)  >= 32'(COLS)) || (32'(gh_y)  >= 32'(ROWS));

    // After two back-to-back VGA grants, a pending pacman/ghost request goes first.
    assign w_vga_block = (r_vga_streak == 2'd2) && (pac_req || gh_req);

    // Grant selection: VGA priority with anti-starvation, else pacman/ghost round-robin.
    always_comb begin
        w_gnt_vga = 1'b0;
        w_gnt_pac = 1'b0;
        w_gnt_gh  = 1'b0;
        if (vga_req && !w_vga_block) begin
            w_gnt_vga = 1'b1;
        end else if (pac_req && gh_req) begin
            if (r_rr_gh) w_gnt_gh  = 1'b1;
            else         w_gnt_pac = 1'b1;
        end else if (pac_req) begin
            w_gnt_pac = 1'b1;
        end else if (gh_req) begin
            w_gnt_gh = 1'b1;
        end
    end

    // Column c lives at bits [W-1-4c -: 4]; out-of-range lookups never index the word.
    assign w_msb      = r_oob ? AW'(W - 1) : AW'(W - 1) - AW'({r_col, 2'b00});
    assign w_raw_cell = ram_q[w_msb -: 4];
    assign w_cell     = r_oob ? 4'h1 : w_raw_cell;
    assign w_clear_hit = (r_id == ID_PAC) && !r_oob &&
                         ((w_raw_cell == 4'h2) || (w_raw_cell == 4'h3));

    // Write-back word: the row just read with the target cell emptied.
    always_comb begin
        w_clear_word = ram_q;
        w_clear_word[w_msb -: 4] = 4'h0;
    end

    // Arbitration FSM: grant, read, check/report, optional clear write.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_id         <= ID_PAC;
            r_col        <= '0;
            r_oob        <= 1'b0;
            r_pac_done   <= 1'b0;
            r_gh_done    <= 1'b0;
            r_vga_done   <= 1'b0;
            r_pac_cell   <= '0;
            r_gh_cell    <= '0;
            r_vga_word   <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_wren   <= 1'b0;
            r_dot_eaten  <= 1'b0;
            r_pill_eaten <= 1'b0;
            r_dots_left  <= 10'(DOT_TOTAL);
            r_rr_gh      <= 1'b0;
            r_vga_streak <= '0;
        end else begin
            r_pac_done   <= 1'b0;
            r_gh_done    <= 1'b0;
            r_vga_done   <= 1'b0;
            r_ram_wren   <= 1'b0;
            r_dot_eaten  <= 1'b0;
            r_pill_eaten <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_vga) begin
                        r_id       <= ID_VGA;
                        r_ram_addr <= vga_row;
                        r_col      <= '0;
                        r_oob      <= 1'b0;
                        if (r_vga_streak != 2'd2)
                            r_vga_streak <= r_vga_streak + 2'd1;
                        r_state    <= S_RD;
                    end else if (w_gnt_pac) begin
                        r_id         <= ID_PAC;
                        r_ram_addr   <= pac_y;
                        r_col        <= pac_x;
                        r_oob        <= w_pac_oob;
                        r_rr_gh      <= 1'b1;
                        r_vga_streak <= '0;
                        r_state      <= S_RD;
                    end else if (w_gnt_gh) begin
                        r_id         <= ID_GH;
                        r_ram_addr   <= gh_y;
                        r_col        <= gh_x;
                        r_oob        <= w_gh_oob;
                        r_rr_gh      <= 1'b0;
                        r_vga_streak <= '0;
                        r_state      <= S_RD;
                    end
                end
                S_RD: begin
                    // Done pulses are registered here so they land in CHK,
                    // the cycle in which ram_q carries the requested row.
                    r_pac_done <= (r_id == ID_PAC);
                    r_gh_done  <= (r_id == ID_GH);
                    r_vga_done <= (r_id == ID_VGA);
                    r_state    <= S_CHK;
                end
                S_CHK: begin
                    unique case (r_id)
                        ID_PAC:  r_pac_cell <= w_cell;
                        ID_GH:   r_gh_cell  <= w_cell;
                        default: r_vga_word <= ram_q;
                    endcase
                    if (w_clear_hit) begin
                        r_ram_wdata  <= w_clear_word;
                        r_ram_wren   <= 1'b1;
                        r_dot_eaten  <= (w_raw_cell == 4'h2);
                        r_pill_eaten <= (w_raw_cell == 4'h3);
                        r_state      <= S_WR;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (r_dot_eaten && (r_dots_left != '0))
                        r_dots_left <= r_dots_left - 10'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pac_done = r_pac_done;
    assign gh_done  = r_gh_done;
    assign vga_done = r_vga_done;

    // Data is shown straight from ram_q during the done cycle and held afterwards.
    assign pac_cell = r_pac_done ? w_cell : r_pac_cell;
    assign gh_cell  = r_gh_done  ? w_cell : r_gh_cell;
    assign vga_word = r_vga_done ? ram_q  : r_vga_word;

    // Reset during WR must suppress the write that is already on the bus.
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign ram_wren   = r_ram_wren   & ~reset;
    assign dot_eaten  = r_dot_eaten  & ~reset;
    assign pill_eaten = r_pill_eaten & ~reset;

    assign dots_left   = r_dots_left;
    assign level_clear = (r_dots_left == '0);

endmodule

// File: tb/tb_map_access_arbiter.sv
// Scoreboard bench for map_access_arbiter: a behavioural RAM, a shadow map
// that predicts reads and clear writes, and per-requester expectation queues.
module tb_map_access_arbiter;

    localparam int COLS      = 40;
    localparam int ROWS      = 32;
    localparam int DOT_TOTAL = 300;
    localparam int W         = COLS * 4;

    logic            CLOCK_50;
    logic            reset;
    logic            pac_req, gh_req, vga_req;
    logic [5:0]      pac_x, gh_x;
    logic [4:0]      pac_y, gh_y, vga_row;
    logic            pac_done, gh_done, vga_done;
    logic [3:0]      pac_cell, gh_cell;
    logic [W-1:0]    vga_word;
    logic [4:0]      ram_addr;
    logic [W-1:0]    ram_wdata;
    logic            ram_wren;
    logic [W-1:0]    ram_q;
    logic            dot_eaten, pill_eaten;
    logic [9:0]      dots_left;
    logic            level_clear;

    map_access_arbiter #(.COLS(COLS), .ROWS(ROWS), .DOT_TOTAL(DOT_TOTAL)) u_dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .pac_req     (pac_req),
        .pac_x       (pac_x),
        .pac_y       (pac_y),
        .pac_done    (pac_done),
        .pac_cell    (pac_cell),
        .gh_req      (gh_req),
        .gh_x        (gh_x),
        .gh_y        (gh_y),
        .gh_done     (gh_done),
        .gh_cell     (gh_cell),
        .vga_req     (vga_req),
        .vga_row     (vga_row),
        .vga_done    (vga_done),
        .vga_word    (vga_word),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .dot_eaten   (dot_eaten),
        .pill_eaten  (pill_eaten),
        .dots_left   (dots_left),
        .level_clear (level_clear)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int          exp_dots = DOT_TOTAL;

    logic [W-1:0]   mem    [ROWS];
    logic [W-1:0]   shadow [ROWS];
    logic           init_en;

    logic [3:0]     q_pac [$];
    logic [3:0]     q_gh  [$];
    logic [W-1:0]   q_vga [$];
    logic [W+4:0]   q_wr  [$];
    logic [1:0]     q_eat [$];
    int             log_id  [$];
    int unsigned    log_cyc [$];

    logic [W+4:0]   mon_wr;

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Behavioural single-port RAM, read-first, one-cycle read latency.
    always @(posedge CLOCK_50) begin
        if (init_en) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= shadow[r];
        end else begin
            if (ram_wren) mem[ram_addr] <= ram_wdata;
            ram_q <= mem[ram_addr];
        end
    end

    // Output monitor: every done, write and eaten pulse must match a prediction.
    always @(negedge CLOCK_50) begin
        if (pac_done) begin
            log_id.push_back(0); log_cyc.push_back(cyc);
            if (q_pac.size() == 0) check_val("pac_unexp", 192'(pac_done), 192'(0));
            else check_val("pac_cell", 192'(pac_cell), 192'(q_pac.pop_front()));
        end
        if (gh_done) begin
            log_id.push_back(1); log_cyc.push_back(cyc);
            if (q_gh.size() == 0) check_val("gh_unexp", 192'(gh_done), 192'(0));
            else check_val("gh_cell", 192'(gh_cell), 192'(q_gh.pop_front()));
        end
        if (vga_done) begin
            log_id.push_back(2); log_cyc.push_back(cyc);
            if (q_vga.size() == 0) check_val("vga_unexp", 192'(vga_done), 192'(0));
            else check_val("vga_word", 192'(vga_word), 192'(q_vga.pop_front()));
        end
        if (ram_wren) begin
            if (q_wr.size() == 0) check_val("wr_unexp", 192'(ram_wren), 192'(0));
            else begin
                mon_wr = q_wr.pop_front();
                check_val("wr_addr", 192'(ram_addr), 192'(mon_wr[W+4:W]));
                check_val("wr_data", 192'(ram_wdata), 192'(mon_wr[W-1:0]));
            end
        end
        if (dot_eaten || pill_eaten) begin
            if (q_eat.size() == 0) check_val("eat_unexp", 192'({dot_eaten, pill_eaten}), 192'(0));
            else check_val("eaten", 192'({dot_eaten, pill_eaten}), 192'(q_eat.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_cell(input int row, input int col, input logic [3:0] v);
        logic [W-1:0] w;
        w = shadow[row];
        w[W-1-4*col -: 4] = v;
        shadow[row] = w;
    endtask

    // Predict one transaction from the shadow map; who: 0 pac, 1 ghost, 2 vga.
    task automatic predict(input int who, input int x, input int y, output bit wr, output logic [3:0] c);
        logic [W-1:0] w;
        int row;
        bit oob;
        wr  = 1'b0;
        c   = 4'h0;
        row = y % ROWS;
        if (who == 2) begin
            q_vga.push_back(shadow[row]);
            return;
        end
        oob = (x >= COLS) || (y >= ROWS);
        w   = shadow[row];
        if (oob) c = 4'h1;
        else     c = w[W-1-4*x -: 4];
        if (who == 0) q_pac.push_back(c);
        else          q_gh.push_back(c);
        if (who == 0 && !oob && (c == 4'h2 || c == 4'h3)) begin
            w[W-1-4*x -: 4] = 4'h0;
            shadow[row] = w;
            q_wr.push_back({5'(row), w});
            q_eat.push_back((c == 4'h2) ? 2'b10 : 2'b01);
            if (c == 4'h2 && exp_dots != 0) exp_dots--;
            wr = 1'b1;
        end
    endtask

    // One isolated transaction from IDLE, with latency and hold checks.
    task automatic single(input int who, input int x, input int y);
        bit wr;
        logic [3:0] c;
        int n;
        logic done;
        predict(who, x, y, wr, c);
        case (who)
            0: begin pac_x = 6'(x); pac_y = 5'(y); pac_req = 1'b1; end
            1: begin gh_x  = 6'(x); gh_y  = 5'(y); gh_req  = 1'b1; end
            default: begin vga_row = 5'(y); vga_req = 1'b1; end
        endcase
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
            if (n == 2) begin
                check_val($sformatf("rd_addr_%0d", who), 192'(ram_addr), 192'(y % ROWS));
                check_val($sformatf("rd_wren_%0d", who), 192'(ram_wren), 192'(0));
            end
            done = (who == 0) ? pac_done : (who == 1) ? gh_done : vga_done;
        end while (!done && n < 20);
        // Request set in grant cycle N; third negedge after that is cycle N+2.
        check_val($sformatf("latency_%0d", who), 192'(n), 192'(3));
        tick();
        pac_req = 1'b0; gh_req = 1'b0; vga_req = 1'b0;
        if (wr) begin
            @(negedge CLOCK_50);
            check_val("wr_next_cycle", 192'(ram_wren), 192'(1));
        end
        repeat (2) tick();
        if (who == 0) check_val("pac_hold", 192'(pac_cell), 192'(c));
        if (who == 1) check_val("gh_hold", 192'(gh_cell), 192'(c));
        check_val("dots_left", 192'(dots_left), 192'(exp_dots));
        check_val("level_clear", 192'(level_clear), 192'(exp_dots == 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        exp_dots = DOT_TOTAL;
    endtask

    // Hold requests until n_done dones are logged, then release all of them.
    task automatic hold_until(input int n_done);
        int n;
        n = 0;
        while (log_id.size() < n_done && n < 100) begin
            tick();
            n++;
        end
        pac_req = 1'b0; gh_req = 1'b0; vga_req = 1'b0;
        check_val("burst_count", 192'(log_id.size()), 192'(n_done));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wr;
        logic [3:0] c;
        int n;
        int exp_order [6];

        pac_req = 0; gh_req = 0; vga_req = 0;
        pac_x = 0; pac_y = 0; gh_x = 0; gh_y = 0; vga_row = 0;
        for (int r = 0; r < ROWS; r++) shadow[r] = '0;
        set_cell(5, 3, 4'h2);
        set_cell(5, 7, 4'h2);
        set_cell(5, 8, 4'hA);
        set_cell(5, 9, 4'h1);
        set_cell(0, 0, 4'h3);
        set_cell(6, 39, 4'h3);
        for (int r = 10; r < 18; r++) shadow[r] = {COLS{4'h2}};
        shadow[20] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};

        init_en = 1'b1;
        reset   = 1'b1;
        repeat (2) tick();
        init_en = 1'b0;
        do_reset();

        check_val("rst_pac_cell", 192'(pac_cell), 192'(0));
        check_val("rst_gh_cell", 192'(gh_cell), 192'(0));
        check_val("rst_vga_word", 192'(vga_word), 192'(0));
        check_val("rst_done", 192'({pac_done, gh_done, vga_done}), 192'(0));
        check_val("rst_ram_addr", 192'(ram_addr), 192'(0));
        check_val("rst_ram_wdata", 192'(ram_wdata), 192'(0));
        check_val("rst_ram_wren", 192'(ram_wren), 192'(0));
        check_val("rst_dots_left", 192'(dots_left), 192'(DOT_TOTAL));
        check_val("rst_level_clear", 192'(level_clear), 192'(0));

        single(0, 3, 5);     // dot: clear + count down
        single(0, 0, 0);     // pill in column 0
        single(0, 39, 6);    // pill in last column
        single(1, 7, 5);     // ghost on a dot: read only
        single(1, 7, 5);
        single(0, 8, 5);     // unknown code passes through
        single(0, 9, 5);     // wall
        single(0, 45, 7);    // out of range
        single(0, 40, 5);    // first out-of-range column, row holds data
        single(1, 63, 5);
        single(2, 0, 20);    // renderer row
        single(0, 3, 5);     // previously cleared cell now empty

        // Pacman and ghost together from a fresh pointer: pac, gh, pac.
        do_reset();
        log_id.delete(); log_cyc.delete();
        predict(0, 1, 2, wr, c);
        predict(1, 2, 2, wr, c);
        predict(0, 1, 2, wr, c);
        pac_x = 1; pac_y = 2; gh_x = 2; gh_y = 2;
        pac_req = 1'b1; gh_req = 1'b1;
        hold_until(3);
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
        for (int i = 0; i < 3; i++) check_val($sformatf("rr_order%0d", i), 192'(log_id[i]), 192'(exp_order[i]));
        for (int i = 1; i < 3; i++) check_val($sformatf("rr_gap%0d", i), 192'(log_cyc[i] - log_cyc[i-1]), 192'(3));
        repeat (2) tick();

        // VGA held with pacman pending: V, V, pac, V, V, pac.
        do_reset();
        log_id.delete(); log_cyc.delete();
        exp_order[0] = 2; exp_order[1] = 2; exp_order[2] = 0;
        exp_order[3] = 2; exp_order[4] = 2; exp_order[5] = 0;
        for (int i = 0; i < 6; i++) predict(exp_order[i], 5, (exp_order[i] == 2) ? 20 : 3, wr, c);
        pac_x = 5; pac_y = 3; vga_row = 20;
        pac_req = 1'b1; vga_req = 1'b1;
        hold_until(6);
        for (int i = 0; i < 6; i++) check_val($sformatf("vga_order%0d", i), 192'(log_id[i]), 192'(exp_order[i]));
        for (int i = 1; i < 6; i++) check_val($sformatf("vga_gap%0d", i), 192'(log_cyc[i] - log_cyc[i-1]), 192'(3));
        repeat (2) tick();

        // Eat the full dot budget, then one more to exercise saturation.
        for (int i = 0; i < DOT_TOTAL; i++) single(0, i % COLS, 10 + i / COLS);
        check_val("budget_clear", 192'(level_clear), 192'(1));
        single(0, 20, 17);
        check_val("sat_dots", 192'(dots_left), 192'(0));

        // Reset during the clear write: nothing written, counter reloaded.
        q_pac.push_back(4'h2);
        pac_x = 21; pac_y = 17; pac_req = 1'b1;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (!pac_done && n < 20);
        check_val("abort_latency", 192'(n), 192'(3));
        tick();
        pac_req = 1'b0;
        reset   = 1'b1;
        @(negedge CLOCK_50);
        check_val("abort_wren", 192'(ram_wren), 192'(0));
        check_val("abort_eaten", 192'({dot_eaten, pill_eaten}), 192'(0));
        tick();
        reset = 1'b0;
        exp_dots = DOT_TOTAL;
        check_val("abort_dots", 192'(dots_left), 192'(DOT_TOTAL));
        check_val("abort_done", 192'({pac_done, gh_done, vga_done}), 192'(0));
        single(1, 21, 17);   // dot must still be present

        repeat (3) tick();
        check_val("q_pac_left", 192'(q_pac.size()), 192'(0));
        check_val("q_gh_left", 192'(q_gh.size()), 192'(0));
        check_val("q_vga_left", 192'(q_vga.size()), 192'(0));
        check_val("q_wr_left", 192'(q_wr.size()), 192'(0));
        check_val("q_eat_left", 192'(q_eat.size()), 192'(0));
        for (int r = 0; r < ROWS; r++) check_val($sformatf("mem_row%0d", r), 192'(mem[r]), 192'(shadow[r]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
